// File: rtl/fg_cfg_dac_ctrl.sv
// Host config bank (shadow/active, synchronised strobe, atomic commit) and a paced parallel-DAC writer
// with a 1-deep pending buffer and a saturating drop counter.
module fg_cfg_dac_ctrl #(
  parameter int NUM_REGS    = 8,
  parameter int REG_W       = 8,
  parameter int ADDR_W      = 4,
  parameter int COMMIT_ADDR = 2**ADDR_W-1,
  parameter int AUTO_COMMIT = 0,
  parameter int SYNC_STAGES = 2,
  parameter int DAC_W       = 8,
  parameter int WR_PULSE    = 2,
  parameter int SETTLE      = 4,
  parameter int DROP_W      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en_async_i,
  input  logic [ADDR_W-1:0]         addr_i,
  input  logic [REG_W-1:0]          data_i,
  output logic [NUM_REGS*REG_W-1:0] cr_bus_o,
  output logic                      cr_update_o,
  input  logic [DAC_W-1:0]          sample_i,
  input  logic                      sample_valid_i,
  output logic [DAC_W-1:0]          dac_data_o,
  output logic                      dac_wr_n_o,
  output logic                      dac_clr_n_o,
  output logic                      dac_pd_n_o,
  output logic                      busy_o,
  output logic [DROP_W-1:0]         drop_cnt_o
);

  localparam int CNT_MAX = (WR_PULSE > SETTLE) ? WR_PULSE : SETTLE;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_SETTLE} dac_state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_prev_q, sync_prev_d;
  logic                   wr_pulse, do_commit;
  logic [REG_W-1:0]       shadow_q [NUM_REGS];
  logic [REG_W-1:0]       shadow_d [NUM_REGS];
  logic [REG_W-1:0]       active_q [NUM_REGS];
  logic [REG_W-1:0]       active_d [NUM_REGS];
  logic                   auto_pend_q, auto_pend_d;
  logic                   cr_update_q, cr_update_d;

  dac_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DAC_W-1:0]       dac_data_q, dac_data_d;
  logic                   wr_n_q, wr_n_d;
  logic                   busy_q, busy_d;
  logic                   pend_vld_q, pend_vld_d;
  logic [DAC_W-1:0]       pend_dat_q, pend_dat_d;
  logic [DROP_W-1:0]      drop_q, drop_d;

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], wr_en_async_i};
    sync_prev_d = sync_q[SYNC_STAGES-1];
    wr_pulse    = sync_q[SYNC_STAGES-1] & ~sync_prev_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    auto_pend_d = 1'b0;
    cr_update_d = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_pulse && addr_i == ADDR_W'(i)) begin
        shadow_d[i] = data_i;
        auto_pend_d = (AUTO_COMMIT != 0);
      end
    end
    // Auto-commit copies the bank one cycle after the shadow write has landed.
    do_commit = auto_pend_q || (wr_pulse && addr_i == ADDR_W'(COMMIT_ADDR));
    if (do_commit) begin
      active_d    = shadow_q;
      cr_update_d = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dac_data_d = dac_data_q;
    pend_vld_d = pend_vld_q;
    pend_dat_d = pend_dat_q;
    drop_d     = drop_q;
    case (state_q)
      S_IDLE: begin
        if (pend_vld_q) begin
          dac_data_d = pend_dat_q;
          state_d    = S_SETUP;
          pend_vld_d = sample_valid_i;
          if (sample_valid_i) pend_dat_d = sample_i;
        end else if (sample_valid_i) begin
          dac_data_d = sample_i;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = CNT_W'(WR_PULSE-1);
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          if (SETTLE == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_SETTLE;
            cnt_d   = CNT_W'(SETTLE-1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
    endcase
    // A sample arriving mid-transfer parks in pending, displacing any older one.
    if (state_q != S_IDLE && sample_valid_i) begin
      if (pend_vld_q && drop_q != '1) drop_d = drop_q + DROP_W'(1);
      pend_vld_d = 1'b1;
      pend_dat_d = sample_i;
    end
    busy_d = (state_d != S_IDLE);
    wr_n_d = (state_d != S_STROBE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
      shadow_q    <= '{default: '0};
      active_q    <= '{default: '0};
      auto_pend_q <= 1'b0;
      cr_update_q <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dac_data_q  <= '0;
      wr_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_dat_q  <= '0;
      drop_q      <= '0;
    end else begin
      sync_q      <= sync_d;
      sync_prev_q <= sync_prev_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      auto_pend_q <= auto_pend_d;
      cr_update_q <= cr_update_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dac_data_q  <= dac_data_d;
      wr_n_q      <= wr_n_d;
      busy_q      <= busy_d;
      pend_vld_q  <= pend_vld_d;
      pend_dat_q  <= pend_dat_d;
      drop_q      <= drop_d;
    end
  end

  always_comb begin
    cr_bus_o = '0;
    for (int i = 0; i < NUM_REGS; i++) cr_bus_o[(NUM_REGS-1-i)*REG_W +: REG_W] = active_q[i];
  end

  assign cr_update_o = cr_update_q;
  assign dac_data_o  = dac_data_q;
  assign dac_wr_n_o  = wr_n_q;
  assign dac_clr_n_o = rst_n;
  assign dac_pd_n_o  = 1'b1;
  assign busy_o      = busy_q;
  assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_fg_cfg_dac_ctrl.sv
// Randomised and directed bench for fg_cfg_dac_ctrl: a default instance plus an AUTO_COMMIT=1 instance.
module tb_fg_cfg_dac_ctrl;

  localparam int P   = 2 + 2 + 4;
  localparam int WRP = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, wr_en_ac;
  logic [3:0]  addr;
  logic [7:0]  data;
  logic [7:0]  sample;
  logic        sample_vld;
  logic [63:0] cr_bus, cr_bus_ac;
  logic        upd, upd_ac;
  logic [7:0]  dac_data, dac_data_ac;
  logic        wr_n, wr_n_ac, clr_n, clr_n_ac, pd_n, pd_n_ac, busy, busy_ac;
  logic [7:0]  drop, drop_ac;
  logic [7:0]  zero_sample = 8'h00;
  logic        zero_vld = 1'b0;

  always #5 clk = ~clk;

  fg_cfg_dac_ctrl dut (
    .clk(clk), .rst_n(rst_n), .wr_en_async_i(wr_en), .addr_i(addr), .data_i(data),
    .cr_bus_o(cr_bus), .cr_update_o(upd), .sample_i(sample), .sample_valid_i(sample_vld),
    .dac_data_o(dac_data), .dac_wr_n_o(wr_n), .dac_clr_n_o(clr_n), .dac_pd_n_o(pd_n),
    .busy_o(busy), .drop_cnt_o(drop)
  );

  fg_cfg_dac_ctrl #(.AUTO_COMMIT(1)) dut_ac (
    .clk(clk), .rst_n(rst_n), .wr_en_async_i(wr_en_ac), .addr_i(addr), .data_i(data),
    .cr_bus_o(cr_bus_ac), .cr_update_o(upd_ac), .sample_i(zero_sample), .sample_valid_i(zero_vld),
    .dac_data_o(dac_data_ac), .dac_wr_n_o(wr_n_ac), .dac_clr_n_o(clr_n_ac), .dac_pd_n_o(pd_n_ac),
    .busy_o(busy_ac), .drop_cnt_o(drop_ac)
  );

  int vectors = 0;
  int miscompares = 0;

  // Register model: [0] default instance, [1] auto-commit instance.
  logic [7:0] sh_m  [2][8];
  logic [7:0] act_m [2][8];
  int upd_cnt, upd_first;

  // DAC model: each accepted sample owns the DAC for P cycles from its start edge.
  int         m_t, m_start, m_drop;
  logic       m_pv;
  logic [7:0] m_pd, m_data;
  logic       e_busy, e_wrn;
  logic [7:0] e_data, e_drop;

  function automatic logic [63:0] exp_bus(input int w);
    logic [63:0] r = '0;
    for (int i = 0; i < 8; i++) r[(7-i)*8 +: 8] = act_m[w][i];
    return r;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 8; i++) begin sh_m[w][i] = 8'h00; act_m[w][i] = 8'h00; end
    m_t = 0; m_start = -1000; m_drop = 0; m_pv = 1'b0; m_pd = 8'h00; m_data = 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_en_ac = 1'b0; sample_vld = 1'b0; sample = 8'h00;
    addr = 4'h0; data = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic host_write(input bit ac, input logic [3:0] a, input logic [7:0] d, input int hold);
    addr = a; data = d;
    if (ac) wr_en_ac = 1'b1; else wr_en = 1'b1;
    upd_cnt = 0; upd_first = -1;
    for (int k = 1; k <= hold + 5; k++) begin
      @(posedge clk); #1;
      if (k == hold) begin wr_en = 1'b0; wr_en_ac = 1'b0; end
      if ((ac ? upd_ac : upd) === 1'b1) begin
        upd_cnt++;
        if (upd_first < 0) upd_first = k;
      end
    end
    if (a < 8) begin
      sh_m[ac][a] = d;
      if (ac) act_m[1][a] = d;
    end
    if (a == 4'hF) for (int i = 0; i < 8; i++) act_m[ac][i] = sh_m[ac][i];
  endtask

  task automatic dac_step(input logic v, input logic [7:0] s);
    int t;
    sample_vld = v; sample = s;
    @(posedge clk);
    t = m_t;
    if (t >= m_start + P) begin
      if (m_pv) begin
        m_data = m_pd; m_start = t; m_pv = v; m_pd = s;
      end else if (v) begin
        m_data = s; m_start = t;
      end
    end else if (v) begin
      if (m_pv && m_drop < 255) m_drop++;
      m_pv = 1'b1; m_pd = s;
    end
    m_t++;
    e_busy = (t < m_start + P - 1);
    e_wrn  = !(t >= m_start + 1 && t <= m_start + WRP);
    e_data = m_data;
    e_drop = 8'(m_drop);
    #1 sample_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_en_ac = 1'b0; sample_vld = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({cr_bus, upd, cr_bus_ac, upd_ac} !== 130'b0) begin
      miscompares++; $display("FAIL reset_regs got %h/%b %h/%b need all 0", cr_bus, upd, cr_bus_ac, upd_ac);
    end
    vectors++;
    if ({dac_data, wr_n, busy, drop, clr_n, pd_n} !== {8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_dac got data=%h wr_n=%b busy=%b drop=%0d clr_n=%b pd_n=%b", dac_data, wr_n, busy, drop, clr_n, pd_n);
    end
    #1 rst_n = 1'b1; #1;
    vectors++;
    if (clr_n !== 1'b1) begin miscompares++; $display("FAIL clr_follow got %b need 1", clr_n); end
    do_reset();
  endtask

  task automatic test_commit();
    host_write(0, 4'h3, 8'hA5, 4);
    vectors++;
    if (cr_bus !== 64'h0 || upd_cnt != 0) begin
      miscompares++; $display("FAIL shadow_only got bus=%h upd=%0d need 0/0", cr_bus, upd_cnt);
    end
    host_write(0, 4'hF, 8'h00, 4);
    vectors++;
    if (cr_bus[39:32] !== 8'hA5 || cr_bus !== exp_bus(0)) begin
      miscompares++; $display("FAIL commit_bus got %h need %h", cr_bus, exp_bus(0));
    end
    vectors++;
    if (upd_cnt != 1 || upd_first != 3) begin
      miscompares++; $display("FAIL commit_pulse got cnt=%0d at=%0d need 1 at 3", upd_cnt, upd_first);
    end
  endtask

  task automatic test_level_hold();
    host_write(0, 4'h0, 8'h11, 20);
    host_write(0, 4'hF, 8'h00, 20);
    vectors++;
    if (upd_cnt != 1) begin miscompares++; $display("FAIL held_commit got %0d pulses need 1", upd_cnt); end
    host_write(0, 4'h0, 8'h22, 4);
    host_write(0, 4'hF, 8'h00, 4);
    vectors++;
    if (cr_bus[63:56] !== 8'h22 || cr_bus !== exp_bus(0)) begin
      miscompares++; $display("FAIL reg0_rewrite got %h need %h", cr_bus, exp_bus(0));
    end
    host_write(0, 4'h9, 8'h55, 4);
    host_write(0, 4'hF, 8'h00, 4);
    vectors++;
    if (cr_bus !== exp_bus(0)) begin
      miscompares++; $display("FAIL unmapped got %h need %h", cr_bus, exp_bus(0));
    end
  endtask

  task automatic test_auto_commit();
    host_write(1, 4'h7, 8'h7F, 4);
    vectors++;
    if (cr_bus_ac[7:0] !== 8'h7F || upd_cnt != 1 || upd_first != 4) begin
      miscompares++;
      $display("FAIL auto_commit got reg7=%h cnt=%0d at=%0d need 7f 1 at 4", cr_bus_ac[7:0], upd_cnt, upd_first);
    end
    host_write(1, 4'hF, 8'h00, 4);
    vectors++;
    if (cr_bus_ac !== exp_bus(1) || upd_cnt != 1) begin
      miscompares++; $display("FAIL auto_recopy got %h cnt=%0d need %h 1", cr_bus_ac, upd_cnt, exp_bus(1));
    end
  endtask

  task automatic test_random_regs();
    for (int n = 0; n < 30; n++) begin
      bit ac = 1'($urandom_range(0, 1));
      logic [3:0] a = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      int exp_upd;
      host_write(ac, a, 8'($urandom), 4 + $urandom_range(0, 3));
      exp_upd = (a == 4'hF || (ac && a < 8)) ? 1 : 0;
      vectors++;
      if ((ac ? cr_bus_ac : cr_bus) !== exp_bus(ac) || upd_cnt != exp_upd) begin
        miscompares++;
        $display("FAIL rand_reg ac=%0d a=%0d got %h/%0d need %h/%0d", ac, a, ac ? cr_bus_ac : cr_bus, upd_cnt, exp_bus(ac), exp_upd);
      end
    end
  endtask

  task automatic test_single_sample();
    int low_cnt = 0, busy_cnt = 0, first_low = -1;
    do_reset();
    dac_step(1'b1, 8'h3C);
    vectors++;
    if ({dac_data, wr_n, busy} !== {8'h3C, 1'b1, 1'b1}) begin
      miscompares++; $display("FAIL setup got data=%h wr_n=%b busy=%b need 3c 1 1", dac_data, wr_n, busy);
    end
    busy_cnt = 1;
    for (int k = 1; k < 14; k++) begin
      dac_step(1'b0, 8'h00);
      if (wr_n === 1'b0) begin low_cnt++; if (first_low < 0) first_low = k; end
      if (busy === 1'b1) busy_cnt++;
      vectors++;
      if ({busy, wr_n, dac_data, drop} !== {e_busy, e_wrn, e_data, e_drop}) begin
        miscompares++; $display("FAIL single_step %0d got %b%b %h %0d need %b%b %h %0d", k, busy, wr_n, dac_data, drop, e_busy, e_wrn, e_data, e_drop);
      end
    end
    vectors++;
    if (low_cnt != 2 || first_low != 1 || busy_cnt != 7) begin
      miscompares++; $display("FAIL single_timing got low=%0d at %0d busy=%0d need 2 at 1 busy 7", low_cnt, first_low, busy_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] wrote [$];
    logic prev_wrn = 1'b1;
    logic [7:0] seq [3] = '{8'h01, 8'h02, 8'h03};
    do_reset();
    for (int k = 0; k < 24; k++) begin
      dac_step(k < 3, k < 3 ? seq[k] : 8'h00);
      if (prev_wrn === 1'b1 && wr_n === 1'b0) wrote.push_back(dac_data);
      prev_wrn = wr_n;
      vectors++;
      if ({busy, wr_n, dac_data, drop} !== {e_busy, e_wrn, e_data, e_drop}) begin
        miscompares++; $display("FAIL b2b_step %0d got %b%b %h %0d need %b%b %h %0d", k, busy, wr_n, dac_data, drop, e_busy, e_wrn, e_data, e_drop);
      end
    end
    vectors++;
    if (wrote.size() != 2 || drop !== 8'd1) begin
      miscompares++; $display("FAIL b2b_count got writes=%0d drop=%0d need 2 1", wrote.size(), drop);
    end else begin
      vectors++;
      if (wrote[0] !== 8'h01 || wrote[1] !== 8'h03) begin
        miscompares++; $display("FAIL b2b_data got %h %h need 01 03", wrote[0], wrote[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lows = 0;
    do_reset();
    host_write(0, 4'h2, 8'hC3, 4);
    host_write(0, 4'hF, 8'h00, 4);
    dac_step(1'b1, 8'hAA);
    dac_step(1'b1, 8'hBB);
    dac_step(1'b1, 8'hCC);
    vectors++;
    if (wr_n !== 1'b0 || drop !== 8'd1 || cr_bus === 64'h0) begin
      miscompares++; $display("FAIL pre_abort got wr_n=%b drop=%0d bus=%h need 0 1 nonzero", wr_n, drop, cr_bus);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({wr_n, busy, drop, dac_data, cr_bus, upd} !== {1'b1, 1'b0, 8'h00, 8'h00, 64'h0, 1'b0}) begin
      miscompares++; $display("FAIL abort got wr_n=%b busy=%b drop=%0d data=%h bus=%h", wr_n, busy, drop, dac_data, cr_bus);
    end
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 20; k++) begin
      dac_step(1'b0, 8'h00);
      if (wr_n === 1'b0 || busy === 1'b1) lows++;
    end
    vectors++;
    if (lows != 0) begin miscompares++; $display("FAIL pending_cleared got %0d active cycles need 0", lows); end
  endtask

  task automatic test_random_dac();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      dac_step($urandom_range(0, 4) == 0, 8'($urandom));
      vectors++;
      if ({busy, wr_n, dac_data, drop} !== {e_busy, e_wrn, e_data, e_drop}) begin
        miscompares++; $display("FAIL rand_dac step %0d got %b%b %h %0d need %b%b %h %0d", k, busy, wr_n, dac_data, drop, e_busy, e_wrn, e_data, e_drop);
      end
    end
  endtask

  task automatic test_drop_saturate();
    do_reset();
    for (int k = 0; k < 330; k++) begin
      dac_step(1'b1, 8'($urandom));
      vectors++;
      if ({busy, wr_n, dac_data, drop} !== {e_busy, e_wrn, e_data, e_drop}) begin
        miscompares++; $display("FAIL sat_step %0d got %b%b %h %0d need %b%b %h %0d", k, busy, wr_n, dac_data, drop, e_busy, e_wrn, e_data, e_drop);
      end
    end
    vectors++;
    if (drop !== 8'hFF) begin miscompares++; $display("FAIL drop_saturate got %0d need 255", drop); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_commit();
    test_level_hold();
    test_auto_commit();
    test_random_regs();
    test_single_sample();
    test_back_to_back();
    test_reset_mid();
    test_random_dac();
    test_drop_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fg_cfg_dac_ctrl.md
Name: fg_cfg_dac_ctrl

Overview:
Parametrised configuration-and-DAC-interface controller for the function generator top level.
- Config side: owns a double-buffered register bank (shadow/active) written through a synchronised, edge-detected host strobe. An explicit commit makes a multi-register update take effect atomically.
- DAC side: paces generator samples onto a parallel DAC with a configurable write-pulse width and settling gap, plus a 1-deep pending buffer and a drop counter.
- Sits between the pads, the generator core's CR bus, and the generator core's sample output.

Parameters:
NUM_REGS, 8, number of config registers (2..16)
REG_W, 8, width of each config register
ADDR_W, 4, host address width; must satisfy 2**ADDR_W > NUM_REGS
COMMIT_ADDR, 2**ADDR_W-1, address whose write triggers commit (must be >= NUM_REGS)
AUTO_COMMIT, 0, 1 = shadow writes propagate to active on the next cycle (no commit needed)
SYNC_STAGES, 2, synchroniser depth for wr_en_async_i (>= 2)
DAC_W, 8, DAC sample width
WR_PULSE, 2, cycles dac_wr_n_o is held low (>= 1)
SETTLE, 4, minimum idle cycles after the strobe before the next setup (>= 0)
DROP_W, 8, drop counter width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
wr_en_async_i  in  1  asynchronous host write strobe, active high
addr_i  in  ADDR_W  host register address; stable while the strobe is high
data_i  in  REG_W  host write data; stable while the strobe is high
cr_bus_o  out  NUM_REGS*REG_W  active registers; reg0 in the MSBs
cr_update_o  out  1  one-cycle pulse when the active bank changes
sample_i  in  DAC_W  sample from the generator
sample_valid_i  in  1  one-cycle sample strobe
dac_data_o  out  DAC_W  DAC data bus
dac_wr_n_o  out  1  DAC write, active low
dac_clr_n_o  out  1  DAC clear, active low
dac_pd_n_o  out  1  DAC power-down, active low
busy_o  out  1  DAC FSM not in IDLE
drop_cnt_o  out  DROP_W  saturating count of overwritten pending samples

Behaviour:
Reset (rst_n low at a clk edge):
- Shadow, active and cr_bus_o = 0; cr_update_o = 0.
- dac_data_o = 0, dac_wr_n_o = 1, busy_o = 0, drop_cnt_o = 0.
- Synchroniser and edge-detect flops cleared; pending buffer empty; FSM to IDLE.
- dac_clr_n_o = rst_n, combinational passthrough. dac_pd_n_o = 1 constant.
- Reset mid-operation aborts any strobe immediately: wr_n is 1 on the cycle after the reset edge.

Host write path:
- wr_en_async_i passes through SYNC_STAGES flops, then a rising-edge detector, giving a 1-cycle wr_pulse.
- A level held high produces exactly one write.
- On wr_pulse, addr_i/data_i are sampled directly (the host keeps them stable):
  - addr < NUM_REGS: shadow[addr] <= data_i.
  - addr == COMMIT_ADDR: active <= shadow (all registers) on the next edge, and cr_update_o pulses in that same cycle.
  - Any other address: ignored, no state change.
- Latency from strobe rise to shadow write: SYNC_STAGES+1 cycles.
- AUTO_COMMIT=1: each shadow write also updates active one cycle later, with a cr_update_o pulse. COMMIT_ADDR then still commits, and is a no-op re-copy that also pulses cr_update_o.

DAC FSM states: IDLE, SETUP, STROBE, SETTLE.
- IDLE: if a sample is available (sample_valid_i, or pending full), load it into dac_data_o and go to SETUP. A pending sample has priority over a simultaneous sample_valid_i, which then goes into pending.
- SETUP (1 cycle): data stable, wr_n = 1.
- STROBE: wr_n = 0 for WR_PULSE cycles; dac_data_o is held.
- SETTLE: wr_n = 1 for SETTLE cycles. If SETTLE = 0, go directly to IDLE.
- busy_o = 1 in every state except IDLE.
- Minimum sample period: 2+WR_PULSE+SETTLE cycles.

Pending buffer and drops:
- sample_valid_i while not in IDLE stores the sample in pending.
- If pending is already full, the new sample overwrites it and drop_cnt_o increments, saturating at all-ones.
- dac_data_o never changes outside IDLE→SETUP.

Test Plan:
1. Reset, then write 0xA5 to addr 3 → cr_bus_o unchanged (all 0) and no cr_update_o; write to addr 15 (commit) → cr_bus_o[39:32]=0xA5 and cr_update_o high for exactly 1 cycle.
2. Hold wr_en_async_i high for 20 cycles with addr 0 and data 0x11, then lower it, then write addr 0 data 0x22 and commit → exactly one shadow write per strobe; active reg0 = 0x22; write to addr 9 (unmapped) → no change.
3. AUTO_COMMIT=1: write 0x7F to addr 7 → cr_bus_o[7:0]=0x7F at SYNC_STAGES+2 cycles after the strobe rise, with one cr_update_o pulse.
4. Single sample 0x3C with defaults → dac_data_o=0x3C one cycle after the sample; wr_n low for exactly 2 cycles starting 1 cycle later; busy_o high for 7 cycles total.
5. Samples 0x01, 0x02, 0x03 on 3 consecutive cycles → DAC writes 0x01 then 0x03; drop_cnt_o=1.
6. Assert rst_n low during STROBE → wr_n=1, busy_o=0 and pending empty the next cycle; drop_cnt_o=0; registers cleared.
